spi_master_xfer: RTL and testbench
==================================

// Module: spi_master_xfer
// PURPOSE
// - SPI master (initiator) that drives cs/sclk/mosi and captures miso. It is the opposite end of
//   the team's oversampled SPI slave FSM.
// - Runs one DATA_W-bit, MSB-first, full-duplex transfer per start request.
// - Supports modes 0-3: CPOL=mode[1], CPHA=mode[0]. The system-side host uses start/busy/done.
// PARAMETERS
// - DATA_W   8  bits per transfer (>=2)
// - CLK_DIV  4  clk cycles per sclk half-period (>=2)
// PORTS
// - clk      in   1       system clock
// - reset    in   1       synchronous, active-high
// - mode     in   2       SPI mode; {CPOL,CPHA}
// - start    in   1       transfer request; accepted only in IDLE
// - tx_data  in   DATA_W  word to send; latched on accept
// - busy     out  1       high in every state except IDLE
// - done     out  1       1-cycle pulse at end of transfer
// - rx_data  out  DATA_W  last received word; updated on done
// - cs       out  1       chip select, active-low
// - sclk     out  1       serial clock
// - mosi     out  1       serial data out
// - miso     in   1       serial data in (synchronised externally)
// BEHAVIOUR
// - Reset values (all outputs registered): cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0;
//   state=IDLE.
// - IDLE:
//   - sclk <= mode[1] every cycle; mode must be stable >=1 cycle before start.
//   - start=1 in cycle T -> latch mode and tx_data -> SETUP.
// - SETUP: cycles T+1..T+CLK_DIV.
//   - cs=0, sclk=CPOL.
//   - mosi = tx MSB if CPHA=0, else 0.
// - RUN: 2*DATA_W half-periods k=0..2N-1, CLK_DIV cycles each.
//   - sclk = CPOL^~k[0]; the edge occurs at the clk that enters k. Even k is a leading edge,
//     odd k a trailing edge.
//   - CPHA=0: miso is captured on the clk producing each even-k edge. mosi advances on odd k,
//     except k=2N-1.
//   - CPHA=1: mosi advances to the next bit on each even-k edge (k=0 -> MSB). miso is captured
//     on each odd-k edge.
// - HOLD: CLK_DIV cycles; cs=0, sclk=CPOL, mosi holds its last bit.
// - DONE: 1 cycle.
//   - cs=1, done=1, busy=1, mosi=0.
//   - rx_data <= receive shift register.
//   - Next state: IDLE.
// - Latency:
//   - cs low for CLK_DIV*(2N+2) cycles.
//   - done asserts in cycle T+1+CLK_DIV*(2N+2).
//   - Each transfer has exactly N sample edges and N leading edges.
// - Boundaries:
//   - start while busy (including the DONE cycle) is ignored and never queued.
//   - start held high -> back-to-back transfers; cs stays high >=2 cycles (DONE+IDLE).
//   - mode/tx_data changes while busy are ignored.
//   - reset mid-transfer -> next cycle holds reset values. No done pulse; rx_data=0.
//   - Half-period counter wraps at CLK_DIV-1; the edge index stops at 2N-1, with no extra edges.
// STRUCTURE
// - Shared package spi_pkg: state encoding (IDLE, SETUP, RUN, HOLD, DONE) and
//   CPOL_BIT=1 / CPHA_BIT=0 constants.
// - Sub-module spi_half_tick: CLK_DIV counter with clear. It emits a tick on the last cycle of
//   each half-period.
// - Top level: FSM, edge counter (clog2(2N+1) bits), TX/RX shift registers.
// TESTING (DATA_W=8, CLK_DIV=2)
// - Mode 0, tx=0xA5, miso looped to mosi:
//   - rx_data=0xA5 and done at T+37.
//   - 8 rising edges; cs low 36 cycles; sclk idles 0.
// - Mode 3, tx=0x3C, miso=1:
//   - rx_data=0xFF; sclk idles 1.
//   - mosi at each rising edge reads 0,0,1,1,1,1,0,0.
// - Modes 1 and 2, behavioural slave returning 0x96 on its shift edges:
//   - rx_data=0x96; slave receives tx=0x5A intact.
// - start pulsed at T+5 during a transfer -> ignored.
// - start held high -> second cs fall exactly 2 cycles after the first cs rise.
// - reset at cycle T+10 (RUN):
//   - next cycle cs=1, sclk=0, busy=0, no done.
//   - A following mode-0 transfer completes correctly.
// - mode changed to 3 during a mode-0 transfer -> current transfer stays mode 0.
//   - sclk goes to 1 the cycle after entering IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer block.
// Contents:
//   spi_state_t  - transfer FSM state encoding (IDLE, SETUP, RUN, HOLD, DONE)
//   CPOL_BIT     - index of the clock-polarity bit within the 2-bit mode
//   CPHA_BIT     - index of the clock-phase bit within the 2-bit mode
//   edge_cnt_w() - width of an edge index able to hold 0..2N
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

    function automatic int unsigned edge_cnt_w(input int unsigned data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer for the SPI master.
// Counts 0..CLK_DIV-1 while enabled and wraps; o_tick is high on the last
// cycle of each half-period. i_clear forces the count back to zero.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   i_en     in   count enable
//   i_clear  in   synchronous clear (priority over i_en)
//   o_tick   out  last cycle of the current half-period
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign o_tick    = i_en && w_at_last;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI master: one DATA_W-bit, MSB-first, full-duplex transfer per accepted
// start, in any of SPI modes 0-3 (mode = {CPOL, CPHA}).
// Frame: SETUP (CLK_DIV cycles, cs low) -> RUN (2*DATA_W half-periods of
// CLK_DIV cycles) -> HOLD (CLK_DIV cycles) -> DONE (1 cycle, done pulse).
// All outputs are registered.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   mode     in   {CPOL, CPHA}; sampled on accept
//   start    in   transfer request, accepted only in IDLE
//   tx_data  in   word to send; sampled on accept
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse at end of transfer
//   rx_data  out  last received word, updated with done
//   cs       out  chip select, active-low
//   sclk     out  serial clock
//   mosi     out  serial data out
//   miso     in   serial data in (already synchronised)
module spi_master_xfer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned KW = edge_cnt_w(DATA_W);
    localparam logic [KW-1:0] K_LAST = KW'(2 * DATA_W - 1);

    spi_state_t        r_state;
    spi_state_t        w_state_nxt;

    logic [KW-1:0]     r_k;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_cpol;
    logic              r_cpha;

    logic [KW-1:0]     w_k_nxt;
    logic [KW-1:0]     w_k_enter;
    logic [DATA_W-1:0] w_tx_nxt;
    logic [DATA_W-1:0] w_rx_nxt;
    logic [DATA_W-1:0] w_rx_data_nxt;
    logic              w_cpol_nxt;
    logic              w_cpha_nxt;
    logic              w_cs_nxt;
    logic              w_sclk_nxt;
    logic              w_mosi_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic              w_edge;
    logic              w_tick;
    logic              w_tick_en;
    logic              w_tick_clr;

    assign w_tick_en  = (r_state == ST_SETUP) || (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign w_tick_clr = !w_tick_en;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_tick_en),
        .i_clear (w_tick_clr),
        .o_tick  (w_tick)
    );

    // An sclk edge is produced at the tick that enters half-period k:
    // from SETUP into k=0, or from k to k+1 while k has not reached the end.
    assign w_edge    = w_tick && ((r_state == ST_SETUP) ||
                                  ((r_state == ST_RUN) && (r_k != K_LAST)));
    assign w_k_enter = (r_state == ST_SETUP) ? '0 : (r_k + KW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_rx_data_nxt = rx_data;
        w_cpol_nxt    = r_cpol;
        w_cpha_nxt    = r_cpha;
        w_cs_nxt      = cs;
        w_sclk_nxt    = sclk;
        w_mosi_nxt    = mosi;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cs_nxt   = 1'b1;
                w_mosi_nxt = 1'b0;
                w_sclk_nxt = mode[CPOL_BIT];
                if (start) begin
                    w_state_nxt = ST_SETUP;
                    w_cpol_nxt  = mode[CPOL_BIT];
                    w_cpha_nxt  = mode[CPHA_BIT];
                    w_tx_nxt    = tx_data;
                    w_rx_nxt    = '0;
                    w_cs_nxt    = 1'b0;
                    w_mosi_nxt  = mode[CPHA_BIT] ? 1'b0 : tx_data[DATA_W-1];
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tick && (r_k == K_LAST)) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DONE;
                    w_cs_nxt      = 1'b1;
                    w_mosi_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_rx_data_nxt = r_rx;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Even k is a leading edge, odd k a trailing edge. The data action on
        // each edge depends only on its parity and CPHA.
        if (w_edge) begin
            w_k_nxt    = w_k_enter;
            w_sclk_nxt = r_cpol ^ ~w_k_enter[0];
            if (!w_k_enter[0]) begin
                if (r_cpha) begin
                    w_mosi_nxt = r_tx[DATA_W-1];
                    w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                end else begin
                    w_rx_nxt   = {r_rx[DATA_W-2:0], miso};
                end
            end else begin
                if (r_cpha) begin
                    w_rx_nxt   = {r_rx[DATA_W-2:0], miso};
                end else if (w_k_enter != K_LAST) begin
                    // MSB is already on the line from SETUP, so the next bit
                    // to present sits one below the top of the shifter.
                    w_mosi_nxt = r_tx[DATA_W-2];
                    w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                end
            end
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k     <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            r_k     <= w_k_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_cpol  <= w_cpol_nxt;
            r_cpha  <= w_cpha_nxt;
            cs      <= w_cs_nxt;
            sclk    <= w_sclk_nxt;
            mosi    <= w_mosi_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            rx_data <= w_rx_data_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Self-checking bench for spi_master_xfer (DATA_W=8, CLK_DIV=2).
// Table of single transfers across modes and miso sources, followed by
// hand-written sequences for ignored start, back-to-back start, reset in
// RUN and a mode change during a transfer.
module tb_spi_master_xfer;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       cs;
    logic       sclk;
    logic       mosi;
    logic       miso;

    logic [1:0] msel;     // 0: loopback, 1: constant 1, 2: behavioural slave
    logic       miso_s;

    spi_master_xfer #(
        .DATA_W  (8),
        .CLK_DIV (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .cs      (cs),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = (msel == 2'd0) ? mosi : ((msel == 2'd1) ? 1'b1 : miso_s);

    // Behavioural SPI slave that sends slv_word and records what it receives.
    logic [1:0] s_mode;
    logic [7:0] slv_word;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    logic       s_act;
    logic       s_prev;

    always @(cs or sclk) begin
        if (cs) begin
            s_act <= 1'b0;
        end else if (!s_act) begin
            s_act  <= 1'b1;
            s_prev <= sclk;
            s_rx   <= 8'h00;
            if (s_mode[0]) begin
                s_tx   <= slv_word;
                miso_s <= 1'b0;
            end else begin
                s_tx   <= {slv_word[6:0], 1'b0};
                miso_s <= slv_word[7];
            end
        end else if (sclk != s_prev) begin
            s_prev <= sclk;
            if ((sclk != s_mode[1]) != s_mode[0]) begin
                s_rx <= {s_rx[6:0], mosi};
            end else begin
                miso_s <= s_tx[7];
                s_tx   <= {s_tx[6:0], 1'b0};
            end
        end
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Results of the most recent xfer() call, indexed by cycle offset from T.
    logic       cs_log   [0:127];
    logic       sclk_log [0:127];
    logic       busy_log [0:127];
    logic       done_log [0:127];
    logic [7:0] rx_log   [0:127];
    int         done_c;
    int         done_cnt;
    int         rises;
    int         cslow;
    int         first_rise;
    int         second_fall;
    logic [7:0] mosi_r;

    // Starts a transfer in cycle T and watches cycles T+1..T+stop_c.
    task automatic xfer(input logic [1:0] m, input logic [7:0] tx, input logic [1:0] ms,
                        input int pulse_at, input int chg_at, input int rst_at,
                        input bit hold, input int stop_c);
        logic prev_cs;
        logic prev_sclk;
        int   falls;
        @(posedge clk); #1;
        mode    = m;
        tx_data = tx;
        msel    = ms;
        s_mode  = m;
        repeat (2) @(posedge clk);
        #1;
        start       = 1'b1;
        done_c      = -1;
        done_cnt    = 0;
        rises       = 0;
        cslow       = 0;
        first_rise  = -1;
        second_fall = -1;
        falls       = 0;
        mosi_r      = 8'h00;
        prev_cs     = 1'b1;
        prev_sclk   = m[1];
        for (int c = 1; c <= stop_c; c++) begin
            @(posedge clk); #1;
            start = hold ? (c <= 38) : (c == pulse_at);
            reset = (c == rst_at);
            if (c == chg_at) mode = 2'b11;
            @(negedge clk);
            cs_log[c]   = cs;
            sclk_log[c] = sclk;
            busy_log[c] = busy;
            done_log[c] = done;
            rx_log[c]   = rx_data;
            if (!cs) cslow++;
            if (!cs && sclk && !prev_sclk) begin
                rises++;
                mosi_r = {mosi_r[6:0], mosi};
            end
            if (cs && !prev_cs && first_rise < 0) first_rise = c;
            if (!cs && prev_cs) begin
                falls++;
                if (falls == 2) second_fall = c;
            end
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            prev_cs   = cs;
            prev_sclk = sclk;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] m;
        logic [7:0] tx;
        logic [1:0] ms;
        int         exp_rx;
        int         exp_slave;   // -1: slave not used
        int         exp_mosi;    // -1: not checked
        int         exp_idle;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        tx_data  = 8'h00;
        msel     = 2'd0;
        s_mode   = 2'b00;
        slv_word = 8'h96;

        vecs[0] = '{2'd0, 8'hA5, 2'd0, 'hA5, -1,    'hA5, 0};
        vecs[1] = '{2'd3, 8'h3C, 2'd1, 'hFF, -1,    'h3C, 1};
        vecs[2] = '{2'd1, 8'h5A, 2'd2, 'h96, 'h5A,  -1,   0};
        vecs[3] = '{2'd2, 8'h5A, 2'd2, 'h96, 'h5A,  -1,   1};
        vecs[4] = '{2'd0, 8'h5A, 2'd2, 'h96, 'h5A,  'h5A, 0};
        vecs[5] = '{2'd3, 8'hC3, 2'd2, 'h96, 'hC3,  'hC3, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cs",   cs,      1);
        chk("reset sclk", sclk,    0);
        chk("reset mosi", mosi,    0);
        chk("reset busy", busy,    0);
        chk("reset done", done,    0);
        chk("reset rx",   rx_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].m, vecs[i].tx, vecs[i].ms, -1, -1, -1, 1'b0, 42);
            chk($sformatf("v%0d rx_data", i),    rx_log[37], vecs[i].exp_rx);
            chk($sformatf("v%0d done cycle", i), done_c,     37);
            chk($sformatf("v%0d done count", i), done_cnt,   1);
            chk($sformatf("v%0d rises", i),      rises,      8);
            chk($sformatf("v%0d cs low", i),     cslow,      36);
            chk($sformatf("v%0d setup busy", i), busy_log[1], 1);
            chk($sformatf("v%0d idle sclk", i),  sclk_log[42], vecs[i].exp_idle);
            chk($sformatf("v%0d idle busy", i),  busy_log[42], 0);
            if (vecs[i].exp_slave >= 0)
                chk($sformatf("v%0d slave rx", i), s_rx, vecs[i].exp_slave);
            if (vecs[i].exp_mosi >= 0)
                chk($sformatf("v%0d mosi at rise", i), mosi_r, vecs[i].exp_mosi);
        end

        // start pulsed during RUN must be dropped, not queued
        xfer(2'd0, 8'h81, 2'd0, 5, -1, -1, 1'b0, 42);
        chk("pulse done count", done_cnt,     1);
        chk("pulse done cycle", done_c,       37);
        chk("pulse rx",         rx_log[37],   'h81);
        chk("pulse idle busy",  busy_log[42], 0);
        chk("pulse idle cs",    cs_log[42],   1);

        // start held high -> back-to-back transfers with a 2-cycle cs gap
        xfer(2'd0, 8'h66, 2'd0, -1, -1, -1, 1'b1, 80);
        chk("held first rise",  first_rise,  37);
        chk("held second fall", second_fall, 39);
        chk("held done count",  done_cnt,    2);

        // reset during RUN
        xfer(2'd0, 8'hF0, 2'd0, -1, -1, 10, 1'b0, 15);
        chk("rst busy before", busy_log[10], 1);
        chk("rst cs",          cs_log[11],   1);
        chk("rst sclk",        sclk_log[11], 0);
        chk("rst busy",        busy_log[11], 0);
        chk("rst rx",          rx_log[11],   0);
        chk("rst done count",  done_cnt,     0);
        chk("rst stays idle",  busy_log[15], 0);
        xfer(2'd0, 8'h3C, 2'd0, -1, -1, -1, 1'b0, 42);
        chk("post-rst rx",     rx_log[37],   'h3C);
        chk("post-rst done",   done_c,       37);

        // mode switched to 3 mid-transfer keeps the transfer in mode 0
        xfer(2'd0, 8'hA5, 2'd0, -1, 3, -1, 1'b0, 42);
        chk("mchg rx",         rx_log[37],   'hA5);
        chk("mchg done",       done_c,       37);
        chk("mchg hold sclk",  sclk_log[36], 0);
        chk("mchg idle0 sclk", sclk_log[38], 0);
        chk("mchg idle1 sclk", sclk_log[39], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
